// File: rtl/plic_claim_arbiter.sv
// PLIC interrupt gateway, priority arbiter and claim/complete register port.
// Request edges latch into pending; the best eligible source is re-registered every cycle.
module plic_claim_arbiter #(
  parameter int unsigned N_interrupts = 32,
  parameter int unsigned PRIO_W       = 3
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [N_interrupts-1:0] hw_interrupt_requests,
  input  logic [31:0]             addr,
  input  logic                    ren,
  input  logic                    wen,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    rambusy,
  output logic                    interrupt_service_request,
  output logic                    interrupt_clear
);
  localparam int unsigned IdW = $clog2(N_interrupts);

  typedef enum logic {StIdle, StResp} state_e;
  state_e state_q, state_d;

  logic [N_interrupts-1:0] pending_q, pending_d;
  logic [N_interrupts-1:0] enable_q, enable_d;
  logic [N_interrupts-1:0] in_flight_q, in_flight_d;
  logic [N_interrupts-1:0] prev_req_q;
  logic [N_interrupts-1:0] edges, elig;
  logic [PRIO_W-1:0]       prio_q [N_interrupts];
  logic [PRIO_W-1:0]       prio_d [N_interrupts];
  logic [PRIO_W-1:0]       thr_q, thr_d;
  logic [PRIO_W-1:0]       best_prio_q, best_prio_d;
  logic [IdW-1:0]          best_id_q, best_id_d;
  logic                    irq_q, irq_d;
  logic                    clear_q, clear_d;

  logic do_read, do_write;
  logic hit_prio, hit_pend, hit_en, hit_thr, hit_claim;
  logic unused_bits;

  assign unused_bits = ^{addr[31:12], addr[1:0], wdata, best_prio_q};

  // Simultaneous ren and wen is a read; the write half is dropped.
  assign do_read  = (state_q == StResp) & ren;
  assign do_write = (state_q == StResp) & wen & ~ren;

  assign hit_prio  = (addr[11:7] == 5'd0);
  assign hit_pend  = (addr[11:2] == 10'h020);
  assign hit_en    = (addr[11:2] == 10'h040);
  assign hit_thr   = (addr[11:2] == 10'h080);
  assign hit_claim = (addr[11:2] == 10'h081);

  always_comb begin
    state_d = state_q;
    rambusy = 1'b0;
    case (state_q)
      StIdle: begin
        if (ren | wen) begin
          rambusy = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    edges       = hw_interrupt_requests & ~prev_req_q;
    edges[0]    = 1'b0;
    pending_d   = pending_q;
    enable_d    = enable_q;
    in_flight_d = in_flight_q;
    prio_d      = prio_q;
    thr_d       = thr_q;
    clear_d     = 1'b0;

    if (do_read && hit_claim) begin
      for (int unsigned i = 1; i < N_interrupts; i++) begin
        if (best_id_q == IdW'(i)) begin
          pending_d[i]   = 1'b0;
          in_flight_d[i] = 1'b1;
        end
      end
    end

    if (do_write) begin
      if (hit_prio) begin
        for (int unsigned i = 1; i < N_interrupts; i++) begin
          if (addr[6:2] == 5'(i)) prio_d[i] = wdata[PRIO_W-1:0];
        end
      end
      if (hit_en) begin
        enable_d    = wdata[N_interrupts-1:0];
        enable_d[0] = 1'b0;
      end
      if (hit_thr) thr_d = wdata[PRIO_W-1:0];
      if (hit_claim) begin
        for (int unsigned i = 1; i < N_interrupts; i++) begin
          if ((wdata[4:0] == 5'(i)) && in_flight_q[i]) begin
            in_flight_d[i] = 1'b0;
            clear_d        = 1'b1;
          end
        end
      end
    end

    // A new edge on the ID being claimed keeps it pending.
    pending_d = pending_d | edges;
  end

  // Strict '>' while scanning upward gives ties to the lowest ID.
  always_comb begin
    elig        = '0;
    best_id_d   = '0;
    best_prio_d = '0;
    for (int unsigned i = 1; i < N_interrupts; i++) begin
      elig[i] = pending_q[i] & enable_q[i] & ~in_flight_q[i] & (prio_q[i] > thr_q);
      if (elig[i] && (prio_q[i] > best_prio_d)) begin
        best_prio_d = prio_q[i];
        best_id_d   = IdW'(i);
      end
    end
    irq_d = |elig;
  end

  always_comb begin
    rdata = '0;
    if (do_read) begin
      if (hit_prio) begin
        for (int unsigned i = 1; i < N_interrupts; i++) begin
          if (addr[6:2] == 5'(i)) rdata[PRIO_W-1:0] = prio_q[i];
        end
      end else if (hit_pend) begin
        rdata[N_interrupts-1:0] = pending_q;
      end else if (hit_en) begin
        rdata[N_interrupts-1:0] = enable_q;
      end else if (hit_thr) begin
        rdata[PRIO_W-1:0] = thr_q;
      end else if (hit_claim) begin
        rdata[IdW-1:0] = best_id_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      enable_q    <= '0;
      in_flight_q <= '0;
      prev_req_q  <= '0;
      thr_q       <= '0;
      best_prio_q <= '0;
      best_id_q   <= '0;
      irq_q       <= 1'b0;
      clear_q     <= 1'b0;
      for (int unsigned i = 0; i < N_interrupts; i++) prio_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      in_flight_q <= in_flight_d;
      prev_req_q  <= hw_interrupt_requests;
      thr_q       <= thr_d;
      best_prio_q <= best_prio_d;
      best_id_q   <= best_id_d;
      irq_q       <= irq_d;
      clear_q     <= clear_d;
      prio_q      <= prio_d;
    end
  end

  assign interrupt_service_request = irq_q;
  assign interrupt_clear           = clear_q;

endmodule

// File: tb/tb_plic_claim_arbiter.sv
// Scoreboard bench for plic_claim_arbiter: a register-level model predicts each bus response,
// a negedge monitor pops and compares responses and interrupt_clear pulses.
module tb_plic_claim_arbiter;
  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] hw_interrupt_requests;
  logic [31:0] addr;
  logic        ren;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rambusy;
  logic        interrupt_service_request;
  logic        interrupt_clear;

  plic_claim_arbiter #(
    .N_interrupts(32),
    .PRIO_W      (3)
  ) dut (
    .CLK                      (CLK),
    .nRST                     (nRST),
    .hw_interrupt_requests    (hw_interrupt_requests),
    .addr                     (addr),
    .ren                      (ren),
    .wen                      (wen),
    .wdata                    (wdata),
    .rdata                    (rdata),
    .rambusy                  (rambusy),
    .interrupt_service_request(interrupt_service_request),
    .interrupt_clear          (interrupt_clear)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        is_rd;
    logic [31:0] rdata;
    logic        clr;
  } sb_t;

  sb_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;

  // Register-level reference state.
  logic [31:0] m_pend, m_en, m_inf, m_req;
  logic [2:0]  m_prio [32];
  logic [2:0]  m_thr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_pend = '0; m_en = '0; m_inf = '0; m_req = '0; m_thr = '0;
    for (int i = 0; i < 32; i++) m_prio[i] = '0;
  endtask

  // Search priorities from the top down, IDs from the bottom up.
  function automatic int m_best();
    int res = 0;
    for (int p = 7; p > int'(m_thr); p--)
      for (int i = 1; i < 32; i++)
        if (res == 0 && m_pend[i] && m_en[i] && !m_inf[i] && int'(m_prio[i]) == p) res = i;
    return res;
  endfunction

  task automatic model_read(input logic [31:0] a, output logic [31:0] v);
    logic [9:0] w = a[11:2];
    int b;
    v = '0;
    if (w < 10'h020) begin
      if (w != 10'd0) v = {29'd0, m_prio[int'(w)]};
    end else if (w == 10'h020) v = m_pend;
    else if (w == 10'h040) v = m_en;
    else if (w == 10'h080) v = {29'd0, m_thr};
    else if (w == 10'h081) begin
      b = m_best();
      v = 32'(b);
      if (b != 0) begin
        m_pend[b] = 1'b0;
        m_inf[b]  = 1'b1;
      end
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, output logic clr);
    logic [9:0] w = a[11:2];
    int id;
    clr = 1'b0;
    if (w < 10'h020) begin
      if (w != 10'd0) m_prio[int'(w)] = d[2:0];
    end else if (w == 10'h040) m_en = d & 32'hFFFF_FFFE;
    else if (w == 10'h080) m_thr = d[2:0];
    else if (w == 10'h081) begin
      id = int'(d[4:0]);
      if (id >= 1 && m_inf[id]) begin
        m_inf[id] = 1'b0;
        clr = 1'b1;
      end
    end
  endtask

  task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic force_exp, input logic [31:0] exp);
    sb_t e;
    logic [31:0] v;
    logic c;
    int n = 0;
    e.is_rd = r; e.rdata = '0; e.clr = 1'b0;
    if (r) begin
      model_read(a, v);
      e.rdata = force_exp ? exp : v;
    end else begin
      model_write(a, d, c);
      e.clr = c;
    end
    sb.push_back(e);
    @(posedge CLK); #1;
    addr = a; wdata = d; ren = r; wen = w;
    do begin
      @(negedge CLK);
      n++;
    end while (rambusy && n < 8);
    if (rambusy) chk("bus_timeout", 32'(rambusy), 32'd0);
    @(posedge CLK); #1;
    ren = 1'b0; wen = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    bus(1'b1, 1'b0, a, $urandom, 1'b0, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(1'b0, 1'b1, a, d, 1'b0, '0);
  endtask

  task automatic claim(input logic [31:0] exp);
    bus(1'b1, 1'b0, 32'h204, '0, 1'b1, exp);
  endtask

  task automatic set_req(input logic [31:0] r);
    logic [31:0] e;
    @(posedge CLK); #1;
    hw_interrupt_requests = r;
    e = r & ~m_req & 32'hFFFF_FFFE;
    m_pend = m_pend | e;
    m_req = r;
  endtask

  task automatic check_irq(input string name);
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    chk(name, 32'(interrupt_service_request), (m_best() != 0) ? 32'd1 : 32'd0);
  endtask

  // Monitor: one scoreboard entry per bus response; interrupt_clear checked every cycle.
  logic clr_exp_now = 1'b0;
  always @(negedge CLK) begin
    sb_t e;
    if (!nRST) begin
      clr_exp_now = 1'b0;
    end else begin
      chk("interrupt_clear", 32'(interrupt_clear), 32'(clr_exp_now));
      clr_exp_now = 1'b0;
      if ((ren | wen) && !rambusy) begin
        if (sb.size() == 0) begin
          chk("unexpected_response", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          if (e.is_rd) chk("rdata", rdata, e.rdata);
          clr_exp_now = e.clr;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    int id;
    logic found;
    nRST = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
    hw_interrupt_requests = '0;
    m_reset();
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;

    // Reset state
    @(negedge CLK);
    chk("reset_irq", 32'(interrupt_service_request), 32'd0);
    chk("reset_rambusy", 32'(rambusy), 32'd0);
    chk("reset_clear", 32'(interrupt_clear), 32'd0);
    rd(32'h080);
    rd(32'h100);

    // Single source
    wr(32'h00C, 32'd2); wr(32'h200, 32'd0); wr(32'h100, 32'h8);
    set_req(32'h8);
    check_irq("single_irq_up");
    claim(32'd3);
    check_irq("single_irq_down");
    wr(32'h204, 32'd3);
    set_req(32'h0);

    // Arbitration: higher priority first, then lowest ID on a tie
    wr(32'h014, 32'd4); wr(32'h024, 32'd6); wr(32'h100, 32'h220);
    set_req(32'h220);
    check_irq("arb_irq");
    claim(32'd9); claim(32'd5);
    wr(32'h204, 32'd9); wr(32'h204, 32'd5);
    set_req(32'h0);
    wr(32'h024, 32'd4);
    set_req(32'h220);
    claim(32'd5); claim(32'd9);
    wr(32'h204, 32'd5); wr(32'h204, 32'd9);
    set_req(32'h0);

    // Threshold
    wr(32'h008, 32'd3); wr(32'h200, 32'd3); wr(32'h100, 32'h4);
    set_req(32'h4);
    check_irq("thr_blocked");
    claim(32'd0);
    wr(32'h200, 32'd2);
    check_irq("thr_open");
    claim(32'd2);
    wr(32'h204, 32'd2);
    set_req(32'h0);
    wr(32'h200, 32'd0);

    // Re-trigger while in flight
    wr(32'h010, 32'd5); wr(32'h100, 32'h10);
    set_req(32'h10);
    claim(32'd4);
    set_req(32'h0);
    set_req(32'h10);
    rd(32'h080);
    check_irq("retrig_no_irq");
    wr(32'h204, 32'd4);
    check_irq("retrig_irq_after_complete");
    claim(32'd4);
    wr(32'h204, 32'd4);
    set_req(32'h0);

    // Bad completes, read/write collision, unmapped access, disable keeps pending
    wr(32'h204, 32'd7); wr(32'h204, 32'd0);
    rd(32'h080);
    bus(1'b1, 1'b1, 32'h200, 32'd7, 1'b0, '0);
    rd(32'h200);
    wr(32'h300, 32'hFFFF_FFFF); rd(32'h300); wr(32'h000, 32'd7); rd(32'h000);
    wr(32'h018, 32'd2); wr(32'h100, 32'h0);
    set_req(32'h40);
    check_irq("disabled_pending");
    wr(32'h100, 32'h40);
    check_irq("reenabled");
    claim(32'd6);
    wr(32'h204, 32'd6);
    set_req(32'h0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: set_req($urandom);
        1: wr(32'($urandom_range(0, 31)) << 2, $urandom);
        2: wr(32'h100 | ($urandom & 32'hFFFF_F003), $urandom);
        3: wr(32'h200, $urandom);
        4, 5: rd(32'h204);
        6: begin
          id = $urandom_range(0, 31);
          found = 1'b0;
          if (m_inf != 0 && $urandom_range(0, 3) != 0) begin
            for (int k = 0; k < 32; k++) begin
              if (!found && m_inf[(id + k) % 32]) begin
                id = (id + k) % 32;
                found = 1'b1;
              end
            end
          end
          wr(32'h204, ($urandom & 32'hFFFF_FFE0) | 32'(id));
        end
        default: begin
          case ($urandom_range(0, 5))
            0: a = 32'($urandom_range(0, 31)) << 2;
            1: a = 32'h080;
            2: a = 32'h100;
            3: a = 32'h200;
            4: a = 32'h204;
            default: a = {20'd0, 12'($urandom)};
          endcase
          a = a | ($urandom & 32'hFFFF_F003);
          d = $urandom;
          if ($urandom_range(0, 1) == 0) rd(a);
          else wr(a, d);
        end
      endcase
      check_irq("rand_irq");
    end

    // Reset asserted while a threshold write sits in RESP
    set_req(32'h0);
    wr(32'h100, 32'hFFFF_FFFE); wr(32'h008, 32'd5);
    @(posedge CLK); #1;
    addr = 32'h200; wdata = 32'd6; wen = 1'b1;
    @(posedge CLK); #1;
    nRST = 1'b0;
    wen = 1'b0;
    m_reset();
    @(posedge CLK); @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    chk("midrst_irq", 32'(interrupt_service_request), 32'd0);
    chk("midrst_rambusy", 32'(rambusy), 32'd0);
    rd(32'h200); rd(32'h100); rd(32'h080); rd(32'h008);
    claim(32'd0);

    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
